cla_add_sub: RTL and testbench

Registered two's-complement adder/subtractor built on a two-level carry-lookahead network, serving as the ADD/SUB datapath of the RISC-V integer ALU. It computes Rs1 + Rs2, or Rs1 − Rs2 when funct7_5 is set (RV32I funct7 bit 5), and produces a signed-overflow flag. Result and flag are registered on CLK when enabled.

---
 rtl/cla_add_sub.sv | 96 +++++++++
 tb/tb_cla_add_sub.sv | 105 ++++++++++
 2 files changed

// File: rtl/cla_add_sub.sv
// rtl/cla_add_sub.sv - registered two's-complement adder/subtractor on a carry-lookahead network
// Bit g/p feed 4-bit blocks, blocks feed 4-block groups, groups feed a flat lookahead from c0.
module cla_add_sub #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [WIDTH-1:0] Rs1,
  input  logic [WIDTH-1:0] Rs2,
  input  logic             En,
  input  logic             funct7_5,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int NB  = WIDTH / 4;
  localparam int NG  = (NB + 3) / 4;
  localparam int NBP = NG * 4;

  logic [WIDTH-1:0] b, g, p, c, sum;
  logic [NBP-1:0]   blk_g, blk_p, blk_c;
  logic [NG-1:0]    grp_g, grp_p, grp_c;
  logic             c0, c_msb_out, ovf_next;

  function automatic logic [1:0] cla_gp(input logic [3:0] gi, input logic [3:0] pi);
    logic gg;
    gg = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    return {&pi, gg};
  endfunction

  function automatic logic [2:0] cla_c(input logic [3:0] gi, input logic [3:0] pi, input logic ci);
    logic c1, c2, c3;
    c1 = gi[0] | (pi[0] & ci);
    c2 = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & ci);
    c3 = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & ci);
    return {c3, c2, c1};
  endfunction

  assign c0 = funct7_5;
  assign b  = Rs2 ^ {WIDTH{funct7_5}};
  assign g  = Rs1 & b;
  assign p  = Rs1 ^ b;

  for (genvar i = 0; i < NBP; i++) begin : g_blk
    if (i < NB) begin : g_real
      logic [1:0] gp;
      logic [2:0] ci;
      assign gp       = cla_gp(g[4*i +: 4], p[4*i +: 4]);
      assign blk_g[i] = gp[0];
      assign blk_p[i] = gp[1];
      assign ci       = cla_c(g[4*i +: 4], p[4*i +: 4], blk_c[i]);
      assign c[4*i +: 4] = {ci, blk_c[i]};
    end else begin : g_pad
      assign blk_g[i] = 1'b0;
      assign blk_p[i] = 1'b0;
    end
  end

  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic [1:0] gp;
    logic [2:0] ci;
    assign gp       = cla_gp(blk_g[4*j +: 4], blk_p[4*j +: 4]);
    assign grp_g[j] = gp[0];
    assign grp_p[j] = gp[1];
    assign ci       = cla_c(blk_g[4*j +: 4], blk_p[4*j +: 4], grp_c[j]);
    assign blk_c[4*j +: 4] = {ci, grp_c[j]};
  end

  // Each group carry is an independent sum of products, so no group waits on another.
  always_comb begin
    logic term;
    grp_c = '0;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k <= j; k++) begin
        term = (k == 0) ? c0 : grp_g[k-1];
        for (int m = k; m < j; m++) term = term & grp_p[m];
        grp_c[j] = grp_c[j] | term;
      end
    end
  end

  assign sum       = p ^ c;
  assign c_msb_out = g[WIDTH-1] | (p[WIDTH-1] & c[WIDTH-1]);
  assign ovf_next  = c[WIDTH-1] ^ c_msb_out;

  always_ff @(posedge CLK) begin
    if (rst) begin
      result   <= '0;
      overflow <= 1'b0;
    end else if (En) begin
      result   <= sum;
      overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_cla_add_sub.sv
// tb/tb_cla_add_sub.sv - directed and random checks of cla_add_sub against an arithmetic model
module tb_cla_add_sub;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] Rs1 = '0;
  logic [31:0] Rs2 = '0;
  logic        En = 1'b0;
  logic        funct7_5 = 1'b0;
  logic [31:0] result;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cla_add_sub #(.WIDTH(32)) dut (
    .CLK(CLK), .rst(rst), .Rs1(Rs1), .Rs2(Rs2), .En(En),
    .funct7_5(funct7_5), .result(result), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] bb, input logic f);
    return f ? a - bb : a + bb;
  endfunction

  function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] bb, input logic f);
    longint x;
    x = f ? (longint'($signed(a)) - longint'($signed(bb))) : (longint'($signed(a)) + longint'($signed(bb)));
    return (x > 64'sd2147483647) || (x < -64'sd2147483648);
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_r, input logic exp_o);
    checks++;
    assert (result === exp_r) else begin
      errors++;
      $error("FAIL %s result got %h expected %h", tag, result, exp_r);
    end
    checks++;
    assert (overflow === exp_o) else begin
      errors++;
      $error("FAIL %s overflow got %b expected %b", tag, overflow, exp_o);
    end
  endtask

  task automatic edge_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] bb, input logic f,
                    input logic [31:0] exp_r, input logic exp_o);
    Rs1 = a; Rs2 = bb; funct7_5 = f; En = 1'b1;
    edge_tick();
    check(tag, exp_r, exp_o);
  endtask

  initial begin
    logic [31:0] a, bb;
    logic        f;

    rst = 1'b1; Rs1 = 32'h12345678; Rs2 = 32'h1; En = 1'b1; funct7_5 = 1'b0;
    edge_tick(); check("reset1", 32'h0, 1'b0);
    edge_tick(); check("reset2", 32'h0, 1'b0);
    rst = 1'b0;
    edge_tick(); check("post_reset", 32'h12345679, 1'b0);

    op("add_5_3",      32'd5,         32'd3, 1'b0, 32'h00000008, 1'b0);
    op("add_max_pos",  32'h7FFFFFFF,  32'd1, 1'b0, 32'h80000000, 1'b1);
    op("add_wrap",     32'hFFFFFFFF,  32'd1, 1'b0, 32'h00000000, 1'b0);
    op("sub_3_5",      32'd3,         32'd5, 1'b1, 32'hFFFFFFFE, 1'b0);
    op("sub_min_1",    32'h80000000,  32'd1, 1'b1, 32'h7FFFFFFF, 1'b1);
    op("sub_0_min",    32'h0,  32'h80000000, 1'b1, 32'h80000000, 1'b1);

    op("hold_load", 32'd5, 32'd3, 1'b0, 32'd8, 1'b0);
    En = 1'b0; Rs1 = 32'd100; Rs2 = 32'd200;
    for (int i = 0; i < 3; i++) begin
      edge_tick(); check("hold", 32'd8, 1'b0);
    end
    En = 1'b1;
    edge_tick(); check("hold_release", 32'd300, 1'b0);

    op("b2b_add", 32'd10,        32'd4,         1'b0, 32'd14,        1'b0);
    op("b2b_sub", 32'd10,        32'd4,         1'b1, 32'd6,         1'b0);
    op("b2b_ovf", 32'h7FFFFFFF,  32'hFFFFFFFF,  1'b1, 32'h80000000,  1'b1);

    Rs1 = 32'h7FFFFFFF; Rs2 = 32'd1; funct7_5 = 1'b0; rst = 1'b1;
    edge_tick(); check("mid_reset", 32'h0, 1'b0);
    rst = 1'b0;
    op("after_mid_reset", 32'd20, 32'd22, 1'b0, 32'd42, 1'b0);

    for (int i = 0; i < 60; i++) begin
      a  = $urandom;
      bb = $urandom;
      f  = 1'($urandom_range(0, 1));
      if (i % 8 == 0) a[31:28] = 4'h7;
      if (i % 8 == 1) bb = 32'h80000000;
      op("random", a, bb, f, ref_res(a, bb, f), ref_ovf(a, bb, f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
